// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Holds the architectural PC, issues one instruction-memory read at a time
//   and hands fetched instruction/PC pairs to decode over valid/ready.
//   A redirect replaces the sequential pc+4 path and squashes any wrong-path
//   fetch that is still in flight.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   redirect_valid, redirect_pc     one-cycle redirect pulse and target
//   imem_req, imem_addr             read request / word-aligned address
//   imem_gnt                        request accepted this cycle
//   imem_rvalid, imem_rdata         read response
//   if_valid, if_pc, if_instr       output register towards decode
//   if_ready                        decode accepts this cycle
//   misalign_err                    sticky misaligned-redirect flag
//
// Configuration macro
//   MISALIGN_TRAP_EN : misaligned redirect sets misalign_err and parks the
//                      unit in HALT until reset. When undefined the low two
//                      target bits are cleared silently and misalign_err is 0.

module fetch_pc_unit #(
    parameter int unsigned             ADDR_W   = 32,
    parameter int unsigned             DATA_W   = 32,
    parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_instr,
    input  logic              if_ready,
    output logic              misalign_err
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
`ifdef MISALIGN_TRAP_EN
        S_DROP,
        S_HALT
`else
        S_DROP
`endif
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic [ADDR_W-1:0] redir_target;
    logic              xfer;
    logic              req_fire;

    assign xfer         = if_valid && if_ready;
    assign redir_target = {redirect_pc[ADDR_W-1:2], 2'b00};

    // Only request when the output register can take the response: either it
    // is empty or decode is draining it in this very cycle.
    assign imem_req  = rst_n && (state == S_REQ) && (!if_valid || if_ready);
    assign imem_addr = pc;
    assign req_fire  = imem_req && imem_gnt;

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (redirect_pc[1:0] != 2'b00);
`else
    logic unused_redirect_lo;
    assign unused_redirect_lo = ^redirect_pc[1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            inflight_pc  <= '0;
            if_valid     <= 1'b0;
            if_pc        <= '0;
            if_instr     <= '0;
            misalign_err <= 1'b0;
        end else begin
            if (xfer) begin
                if_valid <= 1'b0;
            end
`ifdef MISALIGN_TRAP_EN
            if (state == S_HALT) begin
                state <= S_HALT;
            end else if (redirect_valid && misaligned) begin
                misalign_err <= 1'b1;
                if_valid     <= 1'b0;
                state        <= S_HALT;
            end else
`endif
            if (redirect_valid) begin
                pc       <= redir_target;
                if_valid <= 1'b0;
                case (state)
                    // A request granted alongside the redirect is wrong-path;
                    // its response must be swallowed in DROP.
                    S_REQ:   state <= req_fire ? S_DROP : S_REQ;
                    S_WAIT:  state <= imem_rvalid ? S_REQ : S_DROP;
                    S_DROP:  state <= imem_rvalid ? S_REQ : S_DROP;
                    default: state <= S_REQ;
                endcase
            end else begin
                case (state)
                    S_REQ: begin
                        if (req_fire) begin
                            inflight_pc <= pc;
                            state       <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            if_valid <= 1'b1;
                            if_pc    <= inflight_pc;
                            if_instr <= imem_rdata;
                            pc       <= inflight_pc + ADDR_W'(4);
                            state    <= S_REQ;
                        end
                    end
                    S_DROP: begin
                        if (imem_rvalid) begin
                            state <= S_REQ;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        misalign_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_pc_unit #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .if_ready      (if_ready),
        .misalign_err  (misalign_err)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_3C3C;
    endfunction

    // Instruction memory: grant in the request cycle when enabled, respond
    // lat cycles after the cycle following the grant.
    logic        gnt_en = 1'b0;
    int unsigned lat    = 0;
    logic        pend   = 1'b0;
    logic [31:0] paddr  = '0;
    int unsigned cnt    = 0;

    assign imem_gnt    = imem_req && gnt_en;
    assign imem_rvalid = pend && (cnt == 0);
    assign imem_rdata  = instr_of(paddr);

    always @(posedge clk) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else begin
            if (imem_rvalid) pend <= 1'b0;
            if (imem_req && imem_gnt) begin
                pend  <= 1'b1;
                paddr <= imem_addr;
                cnt   <= lat;
            end else if (pend && cnt != 0) begin
                cnt <= cnt - 1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected if_pc values queued by the stimulus, consumed on
    // every decode transfer.
    logic [31:0] exp_q[$];
    logic        gap_chk   = 1'b0;
    logic        have_last = 1'b0;
    int          last_cyc  = 0;

    always @(negedge clk) begin
        if (!gap_chk) have_last = 1'b0;
        if (rst_n && if_valid && if_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_xfer observed_pc=%h expected=none", if_pc);
            end
            if (exp_q.size() != 0) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("xfer_pc", if_pc, e);
                chk("xfer_instr", if_instr, instr_of(e));
            end
            if (gap_chk) begin
                if (have_last) chk("xfer_gap", 32'(cyc - last_cyc), 32'd2);
                have_last = 1'b1;
                last_cyc  = cyc;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Run until the DUT requests address a, then withhold grants.
    task automatic run_until_addr(input logic [31:0] a);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (imem_req && imem_addr == a) found = 1'b1;
        end
        chk("reach_addr", {31'b0, found}, 32'd1);
        gnt_en = 1'b0;
    endtask

    task automatic wait_empty;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b1;
        gnt_en         = 1'b1;
        lat            = 0;

        // Reset values
        repeat (3) tick();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_err", {31'b0, misalign_err}, 32'd0);

        // Streaming from reset: 0,4,8,C at one per two cycles
        rst_n = 1'b1;
        #1;
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        gap_chk = 1'b1;
        tick();
        tick();
        chk("first_valid_lat", {31'b0, if_valid}, 32'd1);
        run_until_addr(32'h10);
        wait_empty();
        gap_chk = 1'b0;

        // Back-pressure: output held stable, no requests while full
        rst_n    = 1'b0;
        if_ready = 1'b0;
        gnt_en   = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.push_back(32'h0);
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("stall_valid", {31'b0, if_valid}, 32'd1);
            chk("stall_pc", if_pc, 32'h0);
            chk("stall_instr", if_instr, instr_of(32'h0));
            chk("stall_req", {31'b0, imem_req}, 32'd0);
            tick();
        end
        if_ready = 1'b1;
        #1;
        chk("resume_req", {31'b0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'h4);
        exp_q.push_back(32'h4);
        run_until_addr(32'h8);
        wait_empty();

        // Redirect while waiting for pc 8's response
        lat    = 2;
        gnt_en = 1'b1;
        tick();
        exp_q.push_back(32'h100);
        redirect(32'h0000_0100);
        lat = 0;
        for (int i = 0; i < 20 && !imem_req; i++) tick();
        chk("redir_req", {31'b0, imem_req}, 32'd1);
        chk("redir_addr", imem_addr, 32'h100);
        run_until_addr(32'h104);
        wait_empty();

        // Redirect in the same cycle as rvalid
        gnt_en = 1'b1;
        tick();
        exp_q.push_back(32'h200);
        redirect(32'h0000_0200);
        run_until_addr(32'h204);
        wait_empty();

        // Redirect in the same cycle as gnt
        gnt_en = 1'b1;
        exp_q.push_back(32'h200);
        redirect(32'h0000_0200);
        run_until_addr(32'h204);
        wait_empty();

        // Wrap-around of pc+4
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        redirect(32'hFFFF_FFF8);
        gnt_en = 1'b1;
        run_until_addr(32'h4);
        wait_empty();

        // Misaligned redirect
`ifdef MISALIGN_TRAP_EN
        redirect(32'h0000_0102);
        chk("trap_err", {31'b0, misalign_err}, 32'd1);
        chk("trap_valid", {31'b0, if_valid}, 32'd0);
        gnt_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("trap_noreq", {31'b0, imem_req}, 32'd0);
            chk("trap_sticky", {31'b0, misalign_err}, 32'd1);
        end
        gnt_en = 1'b0;
        rst_n  = 1'b0;
        tick();
        chk("trap_rst_err", {31'b0, misalign_err}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("trap_rst_req", {31'b0, imem_req}, 32'd1);
`else
        exp_q.push_back(32'h100);
        redirect(32'h0000_0102);
        chk("mis_err", {31'b0, misalign_err}, 32'd0);
        gnt_en = 1'b1;
        run_until_addr(32'h104);
        wait_empty();
        chk("mis_err_after", {31'b0, misalign_err}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
